apb_arbiter: RTL and testbench
==============================

# apb_arbiter

Shares one APB master port (`m_apb_intf`) between `NREQ` APB requesters, e.g. the debug APB access port and a system bus bridge, on the system clock. It arbitrates round-robin on transfer boundaries, replays the granted requester's setup/access phases on the shared port, and routes `pready`/`prdata`/`pslverr` back. Each transfer is atomic: the grant is held from setup until completion.

## Interface
- `NREQ`, default 2: number of requesters, legal range 2..8.
- `TIMEOUT`, default 1024: access-phase cycle limit, 2..65535. Used only with `APB_ARB_TIMEOUT_EN`.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-high reset.
- `s_psel`  in  NREQ  per-requester select.
- `s_penable`  in  NREQ  per-requester enable.
- `s_paddr`  in  NREQ×32  address.
- `s_pwrite`  in  NREQ  write when 1.
- `s_pwdata`  in  NREQ×32  write data.
- `s_pstrb`  in  NREQ×4  byte strobes.
- `s_pprot`  in  NREQ×3  protection.
- `s_prdata`  out  NREQ×32  read data; valid when the matching `s_pready` bit is 1.
- `s_pready`  out  NREQ  completion strobe per requester.
- `s_pslverr`  out  NREQ  error, qualified by `s_pready`.
- `m_apb_intf`  apb_intf.master  shared APB port.
- `busy`  out  1  a transfer is in progress on the shared port.
- `grant_id`  out  3  index of the current or last granted requester.

## Operation
- Requesters follow APB: signals are held stable from `psel` until their `pready`. An ungranted requester simply sees `pready=0`.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: if any `s_psel` is set, the picker selects a winner and registers it in `grant`, then go to SETUP. Otherwise stay in IDLE.
  - SETUP: `m_psel=1`, `m_penable=0`. `m_paddr`, `m_pwrite`, `m_pwdata`, `m_pstrb` and `m_pprot` are a combinational mux of `s_*[grant]`. Go to ACCESS.
  - ACCESS: `m_psel=1`, `m_penable=1`, with the same mux. On `m_pready`:
    - `s_pready[grant]=1` in that cycle.
    - `s_prdata[grant]` takes `m_prdata`; `s_pslverr[grant]` takes `m_pslverr`.
    - Round-robin pointer becomes `grant+1` mod NREQ.
    - Go to IDLE.
- Round-robin: the first requesting index at or after the pointer, wrapping. The pointer resets to 0.
- Non-granted `s_pready`, `s_pslverr` and `s_prdata` are 0.
- A requester that drops `psel` before its grant is ignored. Dropping `psel` after the grant is a protocol violation and its effect is undefined.
- `busy` = state ≠ IDLE.
- Reset values: state IDLE, `m_psel`/`m_penable` 0, `s_pready`/`s_pslverr` all 0, `s_prdata` 0, `grant`/`grant_id` 0, pointer 0, `busy` 0.
- Reset mid-transfer: `m_psel` deasserts immediately and asynchronously. The in-flight requester never receives `pready`.

## Timing
- Request seen in IDLE at cycle T: SETUP at T+1, ACCESS at T+2. With zero wait states, `s_pready` is asserted at T+2.
- The requester therefore sees 1 wait state beyond what the slave adds.
- There is one mandatory IDLE cycle between consecutive shared transfers. Back-to-back throughput is 1 transfer per 3 cycles.
- Simultaneous requests: the single winner is the one nearest the pointer. The others are served in pointer order, so each waits at most NREQ−1 transfers.
- A new request arriving during SETUP/ACCESS is held and considered at the next IDLE.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on SETUP and increments each ACCESS cycle without `m_pready`.
  - When it reaches `TIMEOUT-1` without `m_pready`, that cycle asserts `s_pready[grant]=1`, `s_pslverr[grant]=1`, `s_prdata=0`.
  - The FSM returns to IDLE and `m_psel` drops. The pointer advances as for a normal completion.
- Not defined: ACCESS waits indefinitely for `m_pready`, and no counter logic exists.

## Structure
- `apb_arb_pkg`: state enum (IDLE/SETUP/ACCESS), `NREQ_MAX=8`, `TIMEOUT_DEF=1024`, and the grant index width constant (3).
- Sub-module `rr_picker`: purely combinational. Inputs are the request vector and pointer; outputs are `valid` and the winning index.
- Top: FSM, grant/pointer registers, master mux, response demux, optional timeout counter.

## Test plan
- Single requester 0 write (addr 0x1000_0040, data 0xDEADBEEF), slave zero-wait → master SETUP at T+1 and ACCESS at T+2 carrying exactly those values; `s_pready[0]` high one cycle at T+2.
- Requesters 0 and 1 both assert at T, pointer 0 → req0 served (pready at T+2), req1 granted at IDLE T+3, pready at T+5; `grant_id` shows 0 then 1.
- Both requesting continuously for 6 transfers → grants alternate 0,1,0,1,0,1; no starvation.
- Read with slave 3 wait states, `m_prdata=0x12345678`, `m_pslverr=1` → `s_prdata[1]=0x12345678` and `s_pslverr[1]=1` only in the `pready` cycle; other ports read 0.
- `APB_ARB_TIMEOUT_EN`, `TIMEOUT=16`, slave never ready → `s_pready`+`s_pslverr` at ACCESS cycle 16, `m_psel` low next cycle, next requester served normally.
- Assert `rst` during ACCESS → `m_psel`/`m_penable` low in the same cycle, `busy=0`, pointer 0, no `s_pready` pulse.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and constants for apb_arbiter.
//   - arb_state_e : FSM state encoding (IDLE / SETUP / ACCESS)
//   - NREQ_MAX    : largest supported requester count
//   - TIMEOUT_DEF : default access-phase cycle limit
//   - GID_W       : width of a grant / pointer index
//   - rr_next()   : round-robin successor of an index, modulo n
package apb_arb_pkg;

  localparam int NREQ_MAX    = 8;
  localparam int TIMEOUT_DEF = 1024;
  localparam int GID_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } arb_state_e;

  function automatic logic [GID_W-1:0] rr_next(input logic [GID_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/apb_intf.sv
// apb_intf: single APB3/APB4 link, 32-bit address and data.
//   master modport drives the request (psel..pprot), samples the response
//   (prdata, pready, pslverr); slave modport is the mirror image.
interface apb_intf;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_arbiter_rr_picker.sv
// rr_picker: combinational round-robin picker.
//   req   in  NREQ    request vector
//   ptr   in  GID_W   highest-priority index (must be < NREQ)
//   valid out 1       at least one request is set
//   idx   out GID_W   first requesting index at or after ptr, wrapping
module rr_picker
  import apb_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [GID_W-1:0] ptr,
  output logic             valid,
  output logic [GID_W-1:0] idx
);

  // Rotate the doubled request vector so bit 0 is the pointer position;
  // the lowest set bit is then the offset of the winner from ptr.
  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] rot;
  int                off;
  int                sum;

  assign dbl = {req, req};
  assign rot = dbl >> ptr;

  always_comb begin
    valid = 1'b0;
    off   = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        off   = k;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    idx = GID_W'(sum);
  end

endmodule

// File: rtl/apb_arbiter.sv
// apb_arbiter: shares one APB master port between NREQ requesters.
// Round-robin arbitration on transfer boundaries; the granted requester's
// request is muxed onto m_apb_intf and the response routed back to it only.
//   clk, rst          system clock, async active-high reset
//   s_psel..s_pprot   per-requester APB request inputs
//   s_prdata/pready/pslverr  per-requester response (0 when not granted)
//   m_apb_intf        shared APB master port
//   busy              transfer in progress (state != IDLE)
//   grant_id          current / last granted requester
// Optional feature: define APB_ARB_TIMEOUT_EN to terminate an access phase
// after TIMEOUT cycles with pslverr=1, prdata=0.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      s_psel,
  input  logic [NREQ-1:0]      s_penable,
  input  logic [NREQ-1:0][31:0] s_paddr,
  input  logic [NREQ-1:0]      s_pwrite,
  input  logic [NREQ-1:0][31:0] s_pwdata,
  input  logic [NREQ-1:0][3:0] s_pstrb,
  input  logic [NREQ-1:0][2:0] s_pprot,
  output logic [NREQ-1:0][31:0] s_prdata,
  output logic [NREQ-1:0]      s_pready,
  output logic [NREQ-1:0]      s_pslverr,
  apb_intf.master              m_apb_intf,
  output logic                 busy,
  output logic [2:0]           grant_id
);

  if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("apb_arbiter: NREQ out of range 2..8");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_tmo
    $error("apb_arbiter: TIMEOUT out of range 2..65535");
  end

  arb_state_e       state_q, state_d;
  logic [GID_W-1:0] grant_q, grant_d;
  logic [GID_W-1:0] ptr_q, ptr_d;

  logic             pick_valid;
  logic [GID_W-1:0] pick_idx;

  logic             m_psel, m_penable, m_pwrite;
  logic [31:0]      m_paddr, m_pwdata;
  logic [3:0]       m_pstrb;
  logic [2:0]       m_pprot;

  logic             xfer_done;
  logic             rsp_err;
  logic [31:0]      rsp_data;

  // The arbiter generates its own setup/access phases on the shared port,
  // so the requesters' penable carries no extra information.
  logic unused_penable;
  assign unused_penable = ^s_penable;

`ifdef APB_ARB_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        tmo_hit;
  assign tmo_hit = (tmo_q == 16'(TIMEOUT - 1));
`endif

  rr_picker #(.NREQ(NREQ)) u_pick (
    .req   (s_psel),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  // Master request mux: follows grant_q in every state; only qualified
  // by m_psel outside IDLE.
  always_comb begin
    m_paddr  = '0;
    m_pwrite = 1'b0;
    m_pwdata = '0;
    m_pstrb  = '0;
    m_pprot  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == GID_W'(i)) begin
        m_paddr  = s_paddr[i];
        m_pwrite = s_pwrite[i];
        m_pwdata = s_pwdata[i];
        m_pstrb  = s_pstrb[i];
        m_pprot  = s_pprot[i];
      end
    end
  end

  // FSM next-state, phase control and response demux.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    m_psel    = 1'b0;
    m_penable = 1'b0;
    xfer_done = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    s_pready  = '0;
    s_pslverr = '0;
    s_prdata  = '0;
`ifdef APB_ARB_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        m_psel  = 1'b1;
        state_d = ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      ST_ACCESS: begin
        m_psel    = 1'b1;
        m_penable = 1'b1;
        if (m_apb_intf.pready) begin
          xfer_done = 1'b1;
          rsp_err   = m_apb_intf.pslverr;
          rsp_data  = m_apb_intf.prdata;
        end
`ifdef APB_ARB_TIMEOUT_EN
        // Slave never answered: complete locally with an error.
        else if (tmo_hit) begin
          xfer_done = 1'b1;
          rsp_err   = 1'b1;
          rsp_data  = '0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
        if (xfer_done) begin
          ptr_d   = rr_next(grant_q, NREQ);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (xfer_done) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_q == GID_W'(i)) begin
          s_pready[i]  = 1'b1;
          s_pslverr[i] = rsp_err;
          s_prdata[i]  = rsp_data;
        end
      end
    end
  end

  assign m_apb_intf.psel    = m_psel;
  assign m_apb_intf.penable = m_penable;
  assign m_apb_intf.paddr   = m_paddr;
  assign m_apb_intf.pwrite  = m_pwrite;
  assign m_apb_intf.pwdata  = m_pwdata;
  assign m_apb_intf.pstrb   = m_pstrb;
  assign m_apb_intf.pprot   = m_pprot;

  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: self-checking bench for apb_arbiter (NREQ=2, TIMEOUT=16).
// Table of single transfers plus hand sequences for contention, fairness,
// the optional timeout (when APB_ARB_TIMEOUT_EN is defined) and reset.
module tb_apb_arbiter;
  import apb_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int TMO  = 16;
  localparam int IW   = $clog2(NREQ);
  typedef logic [IW-1:0] rid_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
  logic [NREQ-1:0][31:0] s_paddr, s_pwdata, s_prdata;
  logic [NREQ-1:0][3:0]  s_pstrb;
  logic [NREQ-1:0][2:0]  s_pprot;
  logic                  busy;
  logic [2:0]            grant_id;

  apb_intf bus();

  apb_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_psel     (s_psel),
    .s_penable  (s_penable),
    .s_paddr    (s_paddr),
    .s_pwrite   (s_pwrite),
    .s_pwdata   (s_pwdata),
    .s_pstrb    (s_pstrb),
    .s_pprot    (s_pprot),
    .s_prdata   (s_prdata),
    .s_pready   (s_pready),
    .s_pslverr  (s_pslverr),
    .m_apb_intf (bus),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  // Slave model: pready after sl_waits wait states unless hung.
  int          sl_waits = 0;
  logic        sl_hang  = 1'b0;
  logic [31:0] sl_rdata = '0;
  logic        sl_err   = 1'b0;
  int          wcnt     = 0;
  always @(posedge clk) begin
    if (bus.psel && bus.penable && !bus.pready) wcnt <= wcnt + 1;
    else                                        wcnt <= 0;
  end
  assign bus.pready  = bus.psel && bus.penable && !sl_hang && (wcnt == sl_waits);
  assign bus.prdata  = sl_rdata;
  assign bus.pslverr = sl_err;

  typedef struct {
    rid_t        id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    rid_t        id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic drive(input exp_t e);
    s_psel[e.id]    = 1'b1;
    s_penable[e.id] = 1'b1;
    s_paddr[e.id]   = e.addr;
    s_pwrite[e.id]  = e.wr;
    s_pwdata[e.id]  = e.wdata;
    s_pstrb[e.id]   = e.strb;
    s_pprot[e.id]   = e.prot;
  endtask

  function automatic exp_t mk(input rid_t id, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input logic err, input int c);
    exp_t e;
    e.id = id; e.wr = wr; e.addr = a; e.wdata = wd; e.strb = 4'hF;
    e.prot = 3'(id); e.rdata = rd; e.err = err; e.cyc = c;
    return e;
  endfunction

  // Called at a negedge: checks the current cycle, then advances one clock.
  // Requesters drop psel right after the edge that ends their pready cycle.
  task automatic step();
    logic [NREQ-1:0]       done;
    logic [NREQ-1:0][31:0] ev;
    logic [NREQ-1:0]       ee;
    exp_t                  e;
    done = s_pready;
    if (bus.psel && !bus.penable) begin
      if (sb.size() == 0) fail_now("setup_unexpected");
      else begin
        e = sb[0];
        chk("setup_grant_id", 64'(grant_id), 64'(e.id));
        chk("setup_paddr",    64'(bus.paddr),  64'(e.addr));
        chk("setup_pwrite",   64'(bus.pwrite), 64'(e.wr));
        chk("setup_pwdata",   64'(bus.pwdata), 64'(e.wdata));
        chk("setup_pstrb",    64'(bus.pstrb),  64'(e.strb));
        chk("setup_pprot",    64'(bus.pprot),  64'(e.prot));
      end
    end
    if (|s_pready) begin
      if (sb.size() == 0) fail_now("pready_unexpected");
      else begin
        e = sb.pop_front();
        ev = '0; ev[e.id] = e.rdata;
        ee = '0; ee[e.id] = e.err;
        chk("s_pready",    64'(s_pready), 64'(NREQ'(1) << e.id));
        chk("s_prdata",    64'(s_prdata), 64'(ev));
        chk("s_pslverr",   64'(s_pslverr), 64'(ee));
        chk("pready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    @(posedge clk);
    #1;
    s_psel = s_psel & ~done;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (sb.size() > 0 && n < bound) begin
      step();
      n++;
    end
    if (sb.size() > 0) begin
      fail_now("drain_timeout");
      sb.delete();
    end
  endtask

  vec_t tbl[6];
  exp_t e, e0, e1;
  int   t0, r0, r1, n;

  initial begin
    tbl[0] = '{id:0, wr:1, addr:32'h1000_0040, wdata:32'hDEAD_BEEF, strb:4'hF, prot:3'd0, waits:0, rdata:32'h0, err:0};
    tbl[1] = '{id:1, wr:0, addr:32'h2000_0004, wdata:32'h0, strb:4'h0, prot:3'd1, waits:3, rdata:32'h1234_5678, err:1};
    tbl[2] = '{id:0, wr:0, addr:32'h3000_0100, wdata:32'h0, strb:4'h0, prot:3'd2, waits:1, rdata:32'hA5A5_0F0F, err:0};
    tbl[3] = '{id:1, wr:1, addr:32'h4000_0008, wdata:32'hCAFE_F00D, strb:4'h3, prot:3'd5, waits:0, rdata:32'h1111_0000, err:0};
    tbl[4] = '{id:0, wr:1, addr:32'h5000_00FC, wdata:32'h0102_0304, strb:4'hC, prot:3'd7, waits:2, rdata:32'h0, err:1};
    tbl[5] = '{id:1, wr:0, addr:32'h6000_0010, wdata:32'h0, strb:4'h0, prot:3'd4, waits:2, rdata:32'hFEED_FACE, err:0};

    rst = 1'b1;
    s_psel = '0; s_penable = '0; s_pwrite = '0;
    s_paddr = '0; s_pwdata = '0; s_pstrb = '0; s_pprot = '0;
    @(negedge clk);
    step();
    chk("rst_psel",    64'(bus.psel), 64'(0));
    chk("rst_penable", 64'(bus.penable), 64'(0));
    chk("rst_busy",    64'(busy), 64'(0));
    chk("rst_grant",   64'(grant_id), 64'(0));
    chk("rst_pready",  64'(s_pready), 64'(0));
    chk("rst_prdata",  64'(s_prdata), 64'(0));
    rst = 1'b0;
    step();

    // Table: one transfer at a time, latency 2 + slave wait states.
    for (int i = 0; i < 6; i++) begin
      sl_waits = tbl[i].waits;
      sl_rdata = tbl[i].rdata;
      sl_err   = tbl[i].err;
      e.id = tbl[i].id; e.wr = tbl[i].wr; e.addr = tbl[i].addr;
      e.wdata = tbl[i].wdata; e.strb = tbl[i].strb; e.prot = tbl[i].prot;
      e.rdata = tbl[i].rdata; e.err = tbl[i].err;
      e.cyc = cyc + 2 + tbl[i].waits;
      drive(e);
      sb.push_back(e);
      drain(40);
      chk("idle_busy",   64'(busy), 64'(0));
      chk("idle_pready", 64'(s_pready), 64'(0));
    end

    // Simultaneous requests, pointer at 0: req0 then req1.
    sl_waits = 0; sl_rdata = 32'h0BAD_F00D; sl_err = 1'b0;
    e0 = mk(0, 1, 32'h7000_0000, 32'h5555_AAAA, 32'h0BAD_F00D, 0, cyc + 2);
    e1 = mk(1, 0, 32'h7100_0000, 32'h0,         32'h0BAD_F00D, 0, cyc + 5);
    drive(e0); drive(e1);
    sb.push_back(e0); sb.push_back(e1);
    drain(40);

    // Both requesting continuously: 6 transfers alternate 0,1,0,1,0,1.
    t0 = cyc;
    for (int k = 0; k < 6; k++)
      sb.push_back(mk(rid_t'(k % 2), rid_t'(k % 2) == 0, 32'h8000_0000 + 32'(k % 2),
                      32'h0000_0100 + 32'(k % 2), 32'h0BAD_F00D, 0, t0 + 2 + 3 * k));
    e0 = sb[0]; e1 = sb[1];
    drive(e0); drive(e1);
    r0 = 2; r1 = 2; n = 0;
    while (sb.size() > 0 && n < 100) begin
      step();
      n++;
      if (!s_psel[0] && r0 > 0) begin drive(e0); r0--; end
      if (!s_psel[1] && r1 > 0) begin drive(e1); r1--; end
    end
    if (sb.size() > 0) begin fail_now("fair_timeout"); sb.delete(); end

`ifdef APB_ARB_TIMEOUT_EN
    // Slave never ready: error completion at access cycle TMO.
    sl_hang = 1'b1; sl_rdata = 32'hFFFF_FFFF; sl_err = 1'b0;
    e = mk(0, 0, 32'h9000_0000, 32'h0, 32'h0, 1, cyc + 1 + TMO);
    drive(e); sb.push_back(e);
    drain(60);
    chk("tmo_psel_drop", 64'(bus.psel), 64'(0));
    sl_hang = 1'b0;
    e = mk(1, 1, 32'h9100_0000, 32'h7777_0000, 32'hFFFF_FFFF, 0, cyc + 2);
    drive(e); sb.push_back(e);
    drain(40);
`endif

    // Reset during ACCESS: advance the pointer to 1 first.
    sl_hang = 1'b0; sl_waits = 0; sl_rdata = 32'h3C3C_3C3C; sl_err = 1'b0;
    e = mk(0, 1, 32'hA000_0000, 32'h1, 32'h3C3C_3C3C, 0, cyc + 2);
    drive(e); sb.push_back(e);
    drain(40);
    sl_hang = 1'b1;
    e = mk(1, 1, 32'hA100_0000, 32'h2, 32'h0, 0, -1);
    drive(e); sb.push_back(e);
    step(); step();
    chk("rst_mid_access", 64'(bus.penable), 64'(1));
    rst = 1'b1;
    #1;
    chk("rst_mid_psel",    64'(bus.psel), 64'(0));
    chk("rst_mid_penable", 64'(bus.penable), 64'(0));
    chk("rst_mid_busy",    64'(busy), 64'(0));
    chk("rst_mid_pready",  64'(s_pready), 64'(0));
    chk("rst_mid_grant",   64'(grant_id), 64'(0));
    sb.delete();
    s_psel = '0;
    @(negedge clk);
    step();
    rst = 1'b0; sl_hang = 1'b0;
    // Pointer back at 0: req0 wins over req1.
    e0 = mk(0, 0, 32'hB000_0000, 32'h0, 32'h3C3C_3C3C, 0, cyc + 2);
    e1 = mk(1, 1, 32'hB100_0000, 32'h9, 32'h3C3C_3C3C, 0, cyc + 5);
    drive(e0); drive(e1);
    sb.push_back(e0); sb.push_back(e1);
    drain(40);
    chk("end_busy", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
